// File: rtl/instruction_encoder.sv
// RV32I field-tuple encoder: assembles one 32-bit instruction word per accepted
// tuple and streams it into consecutive instruction-memory addresses until full.
module instruction_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid on the same interface.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [31:0]       word_q, word_nx;
  logic [ADDR_W:0]   count_q, count_nx;
  logic              err_q, err_nx;

  logic              legal;
  logic [31:0]       enc_word;
  logic              last_addr;
  logic              wr_fire;
  logic              in_fire;

  always_comb begin
    legal    = 1'b1;
    enc_word = '0;
    case (opcode)
      7'b0110011: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      7'b0010011: begin
        // Shift-immediates carry funct7 in the top bits and a 5-bit shamt.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else
          enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      end
      7'b0000011,
      7'b1100111: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      7'b0100011: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      7'b1100011: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      7'b0110111,
      7'b0010111: enc_word = {imm[31:12], rd, opcode};
      7'b1101111: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:    legal = 1'b0;
    endcase
  end

  assign last_addr = (addr_q == LAST_ADDR);
  assign mem_we    = (state == HOLD);
  assign full      = (state == FULL);
  assign wr_fire   = mem_we & mem_ready;
  assign in_fire   = in_valid & in_ready;

  // The final write must not admit a refill: there is no address left for it.
  always_comb begin
    case (state)
      EMPTY:   in_ready = 1'b1;
      HOLD:    in_ready = mem_ready & ~last_addr;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    word_nx  = word_q;
    count_nx = count_q;
    err_nx   = 1'b0;
    if (clear) begin
      state_nx = EMPTY;
      addr_nx  = '0;
      count_nx = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            if (legal) begin
              word_nx  = enc_word;
              state_nx = HOLD;
            end else begin
              err_nx = 1'b1;
            end
          end
        end
        HOLD: begin
          if (wr_fire) begin
            count_nx = count_q + (ADDR_W+1)'(1);
            if (last_addr) begin
              state_nx = FULL;
            end else begin
              addr_nx = addr_q + ADDR_W'(1);
              if (in_fire && legal) begin
                word_nx = enc_word;
              end else begin
                state_nx = EMPTY;
                err_nx   = in_fire;
              end
            end
          end
        end
        FULL:    state_nx = FULL;
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      addr_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      addr_q  <= addr_nx;
      word_q  <= word_nx;
      count_q <= count_nx;
      err_q   <= err_nx;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign count     = count_q;
  assign err       = err_q;
  assign fsm_state = state;

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter ADDR_W, default 6: instruction-memory word-address width; depth = 2**ADDR_W.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clear  input  1  sync restart: address counter and full flag to 0; an in-flight word is discarded.
REQ-005 in_valid  input  1  field tuple valid.
REQ-006 in_ready  output  1  encoder accepts the tuple this cycle.
REQ-007 opcode  input  7; rd  input  5; funct3  input  3; rs1  input  5; rs2  input  5; funct7  input  7: RV32I fields.
REQ-008 imm  input  32  immediate, byte-offset form, sign-extended.
REQ-009 mem_we  output  1  write strobe; mem_addr  output  ADDR_W  word address; mem_wdata  output  32  encoded instruction.
REQ-010 mem_ready  input  1  memory accepts the write this cycle.
REQ-011 err  output  1  one-cycle pulse: illegal opcode dropped.
REQ-012 full  output  1  last address written; no further writes.
REQ-013 count  output  ADDR_W+1  words written since reset/clear.

Function
REQ-014 Handshakes: input transfer when in_valid&in_ready; write transfer when mem_we&mem_ready.
REQ-015 FSM states: EMPTY, HOLD, FULL.
REQ-016 EMPTY: in_ready=1, mem_we=0; legal tuple -> encoded word registered -> HOLD next cycle; illegal tuple -> err=1 next cycle, stay EMPTY.
REQ-017 HOLD: mem_we=1; mem_addr, mem_wdata stable until accepted; in_ready=mem_ready (tuple accepted in the same cycle as the write is a back-to-back refill).
REQ-018 On write transfer: count+1, address+1; write to address 2**ADDR_W-1 -> FULL (any same-cycle input not accepted).
REQ-019 Back-to-back: write transfer and legal input transfer in one cycle -> stay HOLD, new word, next address; with illegal input -> EMPTY plus err.
REQ-020 FULL: in_ready=0, mem_we=0, full=1; exited only by clear or reset. Address never wraps.
REQ-021 Latency: one cycle from input transfer to mem_we; throughput one word/cycle with mem_ready=1.
REQ-022 Encoding by opcode (imm bit indices):
- 0110011 R: {funct7,rs2,rs1,funct3,rd,opcode}
- 0010011/0000011/1100111 I: {imm[11:0],rs1,funct3,rd,opcode}; opcode 0010011 with funct3 001/101: {funct7,imm[4:0],rs1,funct3,rd,opcode}
- 0100011 S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
- 1100011 B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
- 0110111/0010111 U: {imm[31:12],rd,opcode}
- 1101111 J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- other opcodes illegal; unused fields ignored; imm bits outside format discarded, no range check.
REQ-023 Illegal opcode: no address or count change; err never asserted with a write for that tuple.
REQ-024 clear has priority over all transfers that cycle: -> EMPTY, count=0, address=0, full=0, err=0.

Reset
REQ-025 reset dominates clear: state EMPTY, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0; in_ready=1 the first cycle after reset deasserts.
REQ-026 Reset mid-HOLD discards the pending word; no write that cycle.

Verification
REQ-027 R/I: add x3,x1,x2 then addi x1,x0,5, mem_ready=1 -> mem_wdata 0x002081B3 @0, then 0x00500093 @1 next cycle; count=2.
REQ-028 S/B/J/U: sw x2,8(x1); beq x1,x2,imm=-4; jal x1,8; lui x5,imm=0x12345000 -> 0x0020A423, 0xFE208EE3, 0x008000EF, 0x123452B7 at consecutive addresses.
REQ-029 Backpressure: mem_ready=0 for 3 cycles in HOLD -> mem_addr/mem_wdata stable, in_ready=0, count unchanged; mem_ready=1 -> single write.
REQ-030 Illegal: opcode 0x7F -> err pulse 1 cycle, no mem_we, count unchanged; following legal tuple written at unchanged address.
REQ-031 Full: ADDR_W=2, 5 legal tuples -> writes @0..3, full=1 and in_ready=0 after 4th, count=4, 5th held off; clear -> count=0, next write @0.
REQ-032 reset asserted in HOLD with mem_ready=0 -> next cycle mem_we=0, count=0, no write of the pending word.
